// File: rtl/rs_muldiv_pkg.sv
// Shared constants for the MUL/DIV reservation station, issue stage and CDB arbiter.
package rs_muldiv_pkg;

    localparam int DATA_W  = 12;
    localparam int TAG_W   = 3;
    localparam int OP_W    = 3;
    localparam int LABEL_W = 2;

    localparam logic [TAG_W-1:0] TAG_NONE = 3'd0;
    localparam logic [OP_W-1:0]  OP_MUL   = 3'b010;
    localparam logic [OP_W-1:0]  OP_DIV   = 3'b011;

    // FU-side state: idle (may dispatch) or one operation in flight
    typedef enum logic {
        FU_IDLE = 1'b0,
        FU_BUSY = 1'b1
    } fu_state_e;

    // Only MUL and DIV belong in this station
    function automatic logic is_muldiv_op(input logic [OP_W-1:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

    // A pending operand wakes when a valid broadcast carries its producer tag; tag 0 never matches
    function automatic logic tag_hit(input logic cdb_valid,
                                     input logic [TAG_W-1:0] cdb_tag,
                                     input logic [TAG_W-1:0] q);
        return cdb_valid && (q != TAG_NONE) && (q == cdb_tag);
    endfunction

endpackage

// File: rtl/rs_entry.sv
// One reservation-station entry: operand capture at allocation, CDB snoop, busy/inflight tracking.
module rs_entry
    import rs_muldiv_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              alloc,
    input  logic [OP_W-1:0]   alloc_op,
    input  logic [DATA_W-1:0] alloc_vj,
    input  logic [DATA_W-1:0] alloc_vk,
    input  logic [TAG_W-1:0]  alloc_qj,
    input  logic [TAG_W-1:0]  alloc_qk,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    input  logic              set_inflight,
    input  logic              free,
    output logic              busy,
    output logic              ready,
    output logic [OP_W-1:0]   op,
    output logic [DATA_W-1:0] vj,
    output logic [DATA_W-1:0] vk
);

    logic              busy_q, busy_d;
    logic              inflight_q, inflight_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [DATA_W-1:0] vj_q, vj_d;
    logic [DATA_W-1:0] vk_q, vk_d;
    logic [TAG_W-1:0]  qj_q, qj_d;
    logic [TAG_W-1:0]  qk_q, qk_d;

    // Next-state: free/inflight control, snoop of pending operands, allocation with same-cycle bypass
    always_comb begin
        busy_d     = busy_q;
        inflight_d = inflight_q;
        op_d       = op_q;
        vj_d       = vj_q;
        vk_d       = vk_q;
        qj_d       = qj_q;
        qk_d       = qk_q;

        if (free) begin
            busy_d     = 1'b0;
            inflight_d = 1'b0;
        end
        if (set_inflight) begin
            inflight_d = 1'b1;
        end

        if (busy_q && tag_hit(cdb_valid, cdb_tag, qj_q)) begin
            vj_d = cdb_data;
            qj_d = TAG_NONE;
        end
        if (busy_q && tag_hit(cdb_valid, cdb_tag, qk_q)) begin
            vk_d = cdb_data;
            qk_d = TAG_NONE;
        end

        // Allocation only targets a free slot, so it never overlaps free/snoop above
        if (alloc) begin
            busy_d     = 1'b1;
            inflight_d = 1'b0;
            op_d       = alloc_op;
            if (tag_hit(cdb_valid, cdb_tag, alloc_qj)) begin
                vj_d = cdb_data;
                qj_d = TAG_NONE;
            end else begin
                vj_d = alloc_vj;
                qj_d = alloc_qj;
            end
            if (tag_hit(cdb_valid, cdb_tag, alloc_qk)) begin
                vk_d = cdb_data;
                qk_d = TAG_NONE;
            end else begin
                vk_d = alloc_vk;
                qk_d = alloc_qk;
            end
        end
    end

    // Control flops: reset clears occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q     <= 1'b0;
            inflight_q <= 1'b0;
        end else begin
            busy_q     <= busy_d;
            inflight_q <= inflight_d;
        end
    end

    // Payload flops: meaningful only while busy, so no reset
    always_ff @(posedge clk) begin
        op_q <= op_d;
        vj_q <= vj_d;
        vk_q <= vk_d;
        qj_q <= qj_d;
        qk_q <= qk_d;
    end

    assign busy  = busy_q;
    assign ready = busy_q && !inflight_q && (qj_q == TAG_NONE) && (qk_q == TAG_NONE);
    assign op    = op_q;
    assign vj    = vj_q;
    assign vk    = vk_q;

endmodule

// File: rtl/rs_muldiv.sv
// MUL/DIV reservation station: allocates issued ops, waits for operands, dispatches one at a time.
module rs_muldiv
    import rs_muldiv_pkg::*;
#(
    parameter int               DEPTH    = 2,
    parameter logic [TAG_W-1:0] BASE_TAG = 3'd5
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              IssueValid,
    input  logic [2:0]        IssueOp,
    input  logic [11:0]       IssueVj,
    input  logic [11:0]       IssueVk,
    input  logic [2:0]        IssueQj,
    input  logic [2:0]        IssueQk,
    output logic              IssueReady,
    output logic [2:0]        IssueTag,
    input  logic              CdbValid,
    input  logic [2:0]        CdbTag,
    input  logic [11:0]       CdbData,
    output logic              FuEn,
    output logic [11:0]       FuRx,
    output logic [11:0]       FuRy,
    output logic [2:0]        FuOp,
    output logic [1:0]        FuLabel,
    input  logic              FuDone,
    input  logic [1:0]        FuLabelIn
);

    logic [DEPTH-1:0]  ent_busy;
    logic [DEPTH-1:0]  ent_ready;
    logic [DEPTH-1:0]  ent_alloc;
    logic [DEPTH-1:0]  ent_set_inflight;
    logic [DEPTH-1:0]  ent_free;
    logic [OP_W-1:0]   ent_op [DEPTH];
    logic [DATA_W-1:0] ent_vj [DEPTH];
    logic [DATA_W-1:0] ent_vk [DEPTH];

    logic [LABEL_W-1:0] free_idx;
    logic               issue_ok;
    logic               sel_found;
    logic [LABEL_W-1:0] sel_idx;
    logic [OP_W-1:0]    sel_op;
    logic [DATA_W-1:0]  sel_vj;
    logic [DATA_W-1:0]  sel_vk;
    logic               done_hit;

    fu_state_e          state_q, state_d;
    logic [DATA_W-1:0]  rx_q, rx_d;
    logic [DATA_W-1:0]  ry_q, ry_d;
    logic [OP_W-1:0]    op_q, op_d;
    logic [LABEL_W-1:0] label_q, label_d;

    genvar g;
    generate
        for (g = 0; g < DEPTH; g++) begin : g_entry
            rs_entry u_entry (
                .clk          (Clock),
                .rst          (Reset),
                .alloc        (ent_alloc[g]),
                .alloc_op     (IssueOp),
                .alloc_vj     (IssueVj),
                .alloc_vk     (IssueVk),
                .alloc_qj     (IssueQj),
                .alloc_qk     (IssueQk),
                .cdb_valid    (CdbValid),
                .cdb_tag      (CdbTag),
                .cdb_data     (CdbData),
                .set_inflight (ent_set_inflight[g]),
                .free         (ent_free[g]),
                .busy         (ent_busy[g]),
                .ready        (ent_ready[g]),
                .op           (ent_op[g]),
                .vj           (ent_vj[g]),
                .vk           (ent_vk[g])
            );
        end
    endgenerate

    // Allocation (lowest free slot) and selection (lowest ready slot); descending scan lets the lowest win
    always_comb begin
        free_idx  = '0;
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_op    = '0;
        sel_vj    = '0;
        sel_vk    = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!ent_busy[i]) begin
                free_idx = LABEL_W'(i);
            end
            if (ent_ready[i]) begin
                sel_found = 1'b1;
                sel_idx   = LABEL_W'(i);
                sel_op    = ent_op[i];
                sel_vj    = ent_vj[i];
                sel_vk    = ent_vk[i];
            end
        end
        IssueReady = !(&ent_busy);
        IssueTag   = BASE_TAG + TAG_W'(free_idx);
        issue_ok   = IssueValid && IssueReady && is_muldiv_op(IssueOp);
        for (int i = 0; i < DEPTH; i++) begin
            ent_alloc[i] = issue_ok && (free_idx == LABEL_W'(i));
        end
    end

    // FU handshake FSM: dispatch only when idle, hold operands until the matching Done
    always_comb begin
        state_d          = state_q;
        rx_d             = rx_q;
        ry_d             = ry_q;
        op_d             = op_q;
        label_d          = label_q;
        ent_set_inflight = '0;
        ent_free         = '0;
        done_hit         = 1'b0;
        case (state_q)
            FU_IDLE: begin
                if (sel_found) begin
                    state_d = FU_BUSY;
                    rx_d    = sel_vj;
                    ry_d    = sel_vk;
                    op_d    = sel_op;
                    label_d = sel_idx;
                    for (int i = 0; i < DEPTH; i++) begin
                        ent_set_inflight[i] = (sel_idx == LABEL_W'(i));
                    end
                end
            end
            FU_BUSY: begin
                done_hit = FuDone && (FuLabelIn == label_q);
                if (done_hit) begin
                    state_d = FU_IDLE;
                    for (int i = 0; i < DEPTH; i++) begin
                        ent_free[i] = (label_q == LABEL_W'(i));
                    end
                end
            end
            default: state_d = FU_IDLE;
        endcase
    end

    // FU state and registered FU outputs
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= FU_IDLE;
            rx_q    <= '0;
            ry_q    <= '0;
            op_q    <= '0;
            label_q <= '0;
        end else begin
            state_q <= state_d;
            rx_q    <= rx_d;
            ry_q    <= ry_d;
            op_q    <= op_d;
            label_q <= label_d;
        end
    end

    assign FuEn    = (state_q == FU_BUSY);
    assign FuRx    = rx_q;
    assign FuRy    = ry_q;
    assign FuOp    = op_q;
    assign FuLabel = label_q;

endmodule

// File: tb/tb_rs_muldiv.sv
// Directed bench for rs_muldiv with hand-computed expectations.
module tb_rs_muldiv;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        IssueValid;
    logic [2:0]  IssueOp;
    logic [11:0] IssueVj, IssueVk;
    logic [2:0]  IssueQj, IssueQk;
    logic        IssueReady;
    logic [2:0]  IssueTag;
    logic        CdbValid;
    logic [2:0]  CdbTag;
    logic [11:0] CdbData;
    logic        FuEn;
    logic [11:0] FuRx, FuRy;
    logic [2:0]  FuOp;
    logic [1:0]  FuLabel;
    logic        FuDone;
    logic [1:0]  FuLabelIn;

    int total = 0;
    int bad   = 0;

    rs_muldiv dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .IssueValid (IssueValid),
        .IssueOp    (IssueOp),
        .IssueVj    (IssueVj),
        .IssueVk    (IssueVk),
        .IssueQj    (IssueQj),
        .IssueQk    (IssueQk),
        .IssueReady (IssueReady),
        .IssueTag   (IssueTag),
        .CdbValid   (CdbValid),
        .CdbTag     (CdbTag),
        .CdbData    (CdbData),
        .FuEn       (FuEn),
        .FuRx       (FuRx),
        .FuRy       (FuRy),
        .FuOp       (FuOp),
        .FuLabel    (FuLabel),
        .FuDone     (FuDone),
        .FuLabelIn  (FuLabelIn)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [11:0] vj, input logic [11:0] vk,
                         input logic [2:0] qj, input logic [2:0] qk);
        IssueValid = 1'b1;
        IssueOp    = op;
        IssueVj    = vj;
        IssueVk    = vk;
        IssueQj    = qj;
        IssueQk    = qk;
    endtask

    task automatic idle_inputs();
        IssueValid = 1'b0;
        IssueOp    = 3'b000;
        IssueVj    = '0;
        IssueVk    = '0;
        IssueQj    = '0;
        IssueQk    = '0;
        CdbValid   = 1'b0;
        CdbTag     = '0;
        CdbData    = '0;
        FuDone     = 1'b0;
        FuLabelIn  = '0;
    endtask

    task automatic done(input logic [1:0] lbl);
        FuDone    = 1'b1;
        FuLabelIn = lbl;
        tick();
        FuDone    = 1'b0;
        FuLabelIn = '0;
    endtask

    task automatic check_fu(input string tag, input logic [11:0] rx, input logic [11:0] ry,
                            input logic [2:0] op, input logic [1:0] lbl);
        check({tag, "_en"},    16'(FuEn),    16'd1);
        check({tag, "_rx"},    16'(FuRx),    16'(rx));
        check({tag, "_ry"},    16'(FuRy),    16'(ry));
        check({tag, "_op"},    16'(FuOp),    16'(op));
        check({tag, "_label"}, 16'(FuLabel), 16'(lbl));
    endtask

    initial begin
        idle_inputs();
        Reset = 1'b1;
        tick();
        tick();
        Reset = 1'b0;

        // Reset state
        check("rst_fuen",  16'(FuEn),       16'd0);
        check("rst_rx",    16'(FuRx),       16'd0);
        check("rst_ry",    16'(FuRy),       16'd0);
        check("rst_op",    16'(FuOp),       16'd0);
        check("rst_label", 16'(FuLabel),    16'd0);
        check("rst_ready", 16'(IssueReady), 16'd1);
        check("rst_tag",   16'(IssueTag),   16'd5);

        // MUL with both operands ready: FuEn two edges after issue
        issue(3'b010, 12'd3, 12'd4, 3'd0, 3'd0);
        check("t1_tag", 16'(IssueTag), 16'd5);
        tick();
        idle_inputs();
        check("t1_en_early", 16'(FuEn), 16'd0);
        check("t1_tag_next", 16'(IssueTag), 16'd6);
        tick();
        check_fu("t1", 12'd3, 12'd4, 3'b010, 2'd0);
        done(2'd0);
        check("t1_done_en",    16'(FuEn),       16'd0);
        check("t1_done_ready", 16'(IssueReady), 16'd1);
        check("t1_done_tag",   16'(IssueTag),   16'd5);

        // DIV waiting on tag 2, woken by the CDB
        issue(3'b011, 12'd0, 12'd5, 3'd2, 3'd0);
        tick();
        idle_inputs();
        tick();
        check("t2_wait", 16'(FuEn), 16'd0);
        CdbValid = 1'b1;
        CdbTag   = 3'd2;
        CdbData  = 12'd20;
        tick();
        idle_inputs();
        check("t2_wake_en", 16'(FuEn), 16'd0);
        tick();
        check_fu("t2", 12'd20, 12'd5, 3'b011, 2'd0);
        done(2'd0);

        // Issue and broadcast of the pending producer in the same cycle
        issue(3'b010, 12'd9, 12'd0, 3'd0, 3'd3);
        CdbValid = 1'b1;
        CdbTag   = 3'd3;
        CdbData  = 12'd7;
        tick();
        idle_inputs();
        tick();
        check_fu("t3", 12'd9, 12'd7, 3'b010, 2'd0);
        done(2'd0);

        // Fill both entries, third issue dropped
        issue(3'b010, 12'd2, 12'd3, 3'd0, 3'd0);
        tick();
        issue(3'b011, 12'd8, 12'd2, 3'd0, 3'd0);
        check("t4_tag1", 16'(IssueTag), 16'd6);
        tick();
        check("t4_full", 16'(IssueReady), 16'd0);
        issue(3'b010, 12'd1, 12'd1, 3'd0, 3'd0);
        tick();
        idle_inputs();
        check("t4_still_full", 16'(IssueReady), 16'd0);
        check_fu("t4a", 12'd2, 12'd3, 3'b010, 2'd0);
        done(2'd0);
        check("t4_gap_en",    16'(FuEn),       16'd0);
        check("t4_gap_ready", 16'(IssueReady), 16'd1);
        check("t4_gap_tag",   16'(IssueTag),   16'd5);
        tick();
        check_fu("t4b", 12'd8, 12'd2, 3'b011, 2'd1);
        done(2'd1);
        check("t4_end_en", 16'(FuEn), 16'd0);
        tick();
        check("t4_dropped", 16'(FuEn), 16'd0);

        // Reset while the FU is busy; a later Done changes nothing
        issue(3'b010, 12'd5, 12'd6, 3'd0, 3'd0);
        tick();
        idle_inputs();
        tick();
        check("t5_en", 16'(FuEn), 16'd1);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check("t5_rst_en",    16'(FuEn),       16'd0);
        check("t5_rst_ready", 16'(IssueReady), 16'd1);
        check("t5_rst_rx",    16'(FuRx),       16'd0);
        done(2'd0);
        check("t5_late_en",  16'(FuEn),     16'd0);
        check("t5_late_tag", 16'(IssueTag), 16'd5);
        tick();
        check("t5_no_disp", 16'(FuEn), 16'd0);

        // Mismatched Done label and illegal opcode are both ignored
        issue(3'b010, 12'd7, 12'd2, 3'd0, 3'd0);
        tick();
        idle_inputs();
        tick();
        check_fu("t6", 12'd7, 12'd2, 3'b010, 2'd0);
        done(2'd1);
        check("t6_badlbl_en", 16'(FuEn), 16'd1);
        check("t6_badlbl_rx", 16'(FuRx), 16'd7);
        issue(3'b000, 12'd1, 12'd1, 3'd0, 3'd0);
        tick();
        idle_inputs();
        check("t6_badop_ready", 16'(IssueReady), 16'd1);
        check("t6_badop_tag",   16'(IssueTag),   16'd6);
        done(2'd0);
        check("t6_done_en", 16'(FuEn), 16'd0);
        tick();
        check("t6_no_disp", 16'(FuEn),     16'd0);
        check("t6_tag_end", 16'(IssueTag), 16'd5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
